// File: rtl/mult_dot_drv.sv
// Dot-product initiator for a ready-valid multiplier: one multiply in flight, products accumulated per vector.
// Optional accumulator saturation is compiled in with `define MULT_DOT_DRV_SAT_EN.
module mult_dot_drv #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2*WIDTH+8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 op_last,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_valid,
  input  logic                 mul_ready,
  input  logic [WIDTH-1:0]     mul_lo,
  input  logic [WIDTH-1:0]     mul_hi,
  input  logic                 mul_rvalid,
  output logic                 mul_rready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 sat,
  output logic                 res_valid,
  input  logic                 res_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;

  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic                   last_r;
  logic [WIDTH-1:0]       a_next_s;
  logic [WIDTH-1:0]       b_next_s;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic [ACC_WIDTH-1:0]   acc_next_s;
  logic [ACC_WIDTH-1:0]   acc_add_s;
  logic [ACC_WIDTH-1:0]   prod_s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_next_s;

  logic                   op_ready_r;
  logic [WIDTH-1:0]       mul_a_r;
  logic [WIDTH-1:0]       mul_b_r;
  logic                   mul_valid_r;
  logic                   mul_rready_r;
  logic [ACC_WIDTH-1:0]   sum_r;
  logic [CNT_WIDTH-1:0]   count_r;
  logic                   res_valid_r;

  logic                   op_fire_s;
  logic                   mul_fire_s;
  logic                   rsp_fire_s;
  logic                   res_fire_s;

  // Handshakes use the registered strobes, which mirror the current state.
  assign op_fire_s  = op_valid   && op_ready_r;
  assign mul_fire_s = mul_valid_r && mul_ready;
  assign rsp_fire_s = mul_rvalid && mul_rready_r;
  assign res_fire_s = res_valid_r && res_ready;

  assign prod_s = ACC_WIDTH'({mul_hi, mul_lo});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_fire_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (mul_fire_s) begin
          state_s = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (rsp_fire_s) begin
          if (last_r) begin
            state_s = DONE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        if (res_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef MULT_DOT_DRV_SAT_EN
  logic [ACC_WIDTH:0] sum_wide_s;
  logic               sat_r;
  logic               sat_next_s;

  // Saturating add: a carry out of the accumulator clamps it and flags sat.
  always_comb begin
    sum_wide_s = {1'b0, acc_r} + {1'b0, prod_s};
    if (sum_wide_s[ACC_WIDTH]) begin
      acc_add_s = {ACC_WIDTH{1'b1}};
    end else begin
      acc_add_s = sum_wide_s[ACC_WIDTH-1:0];
    end
  end

  // Sticky saturation flag, released by the result handshake.
  always_comb begin
    sat_next_s = sat_r;
    if (state_r == WAIT && rsp_fire_s && sum_wide_s[ACC_WIDTH]) begin
      sat_next_s = 1'b1;
    end else if (state_r == DONE && res_fire_s) begin
      sat_next_s = 1'b0;
    end else begin
      sat_next_s = sat_r;
    end
  end

  // Saturation flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= sat_next_s;
    end
  end

  assign sat = sat_r;
`else
  // Wrapping add modulo 2^ACC_WIDTH.
  always_comb begin
    acc_add_s = acc_r + prod_s;
  end

  assign sat = 1'b0;
`endif

  // Accumulator, counter and operand-latch next values.
  always_comb begin
    acc_next_s = acc_r;
    cnt_next_s = cnt_r;
    if (state_r == WAIT && rsp_fire_s) begin
      acc_next_s = acc_add_s;
      cnt_next_s = cnt_r + CNT_WIDTH'(1'b1);
    end else if (state_r == DONE && res_fire_s) begin
      acc_next_s = {ACC_WIDTH{1'b0}};
      cnt_next_s = {CNT_WIDTH{1'b0}};
    end else begin
      acc_next_s = acc_r;
      cnt_next_s = cnt_r;
    end
    if (op_fire_s) begin
      a_next_s = op_a;
      b_next_s = op_b;
    end else begin
      a_next_s = a_r;
      b_next_s = b_r;
    end
  end

  // Datapath state and outputs registered from the next state, so every output is 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      last_r       <= 1'b0;
      acc_r        <= {ACC_WIDTH{1'b0}};
      cnt_r        <= {CNT_WIDTH{1'b0}};
      op_ready_r   <= 1'b0;
      mul_a_r      <= {WIDTH{1'b0}};
      mul_b_r      <= {WIDTH{1'b0}};
      mul_valid_r  <= 1'b0;
      mul_rready_r <= 1'b0;
      sum_r        <= {ACC_WIDTH{1'b0}};
      count_r      <= {CNT_WIDTH{1'b0}};
      res_valid_r  <= 1'b0;
    end else begin
      a_r          <= a_next_s;
      b_r          <= b_next_s;
      if (op_fire_s) begin
        last_r <= op_last;
      end else begin
        last_r <= last_r;
      end
      acc_r        <= acc_next_s;
      cnt_r        <= cnt_next_s;
      op_ready_r   <= (state_s == IDLE);
      mul_valid_r  <= (state_s == ISSUE);
      mul_rready_r <= (state_s == WAIT);
      res_valid_r  <= (state_s == DONE);
      mul_a_r      <= (state_s == ISSUE) ? a_next_s : {WIDTH{1'b0}};
      mul_b_r      <= (state_s == ISSUE) ? b_next_s : {WIDTH{1'b0}};
      sum_r        <= (state_s == DONE) ? acc_next_s : {ACC_WIDTH{1'b0}};
      count_r      <= (state_s == DONE) ? cnt_next_s : {CNT_WIDTH{1'b0}};
    end
  end

  assign op_ready   = op_ready_r;
  assign mul_a      = mul_a_r;
  assign mul_b      = mul_b_r;
  assign mul_valid  = mul_valid_r;
  assign mul_rready = mul_rready_r;
  assign sum        = sum_r;
  assign count      = count_r;
  assign res_valid  = res_valid_r;

endmodule
